// File: rtl/qrs_pkg.sv
// rtl/qrs_pkg.sv - shared types and default lengths for the QRS window sequencer
package qrs_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    WINDOW,
    REFRACT
  } qrs_win_state_t;

  localparam int QRS_WIN_LEN     = 36;
  localparam int QRS_REFRACT_LEN = 72;

endpackage

// File: rtl/sample_counter.sv
// rtl/sample_counter.sv - clearable ce-gated sample counter with terminal flag at MAX-1
module sample_counter #(
  parameter int MAX = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ce,
  output logic tc
);

  localparam int W = $clog2(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/qrs_win_ctrl.sv
// rtl/qrs_win_ctrl.sv - QRS search window / refractory / RR sequencer
// Optional RR measurement built only when QRS_WIN_CTRL_RR_EN is defined.
module qrs_win_ctrl
  import qrs_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int WIN_LEN     = QRS_WIN_LEN,
  parameter int REFRACT_LEN = QRS_REFRACT_LEN,
  parameter int RR_WIDTH    = 11
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] i_feature,
  input  logic                         i_feature_valid,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  input  logic                         i_extremum_found,
  output logic                         o_qrs_win_active,
  output logic                         o_refractory_active,
  output logic                         o_beat,
  output logic                         o_missed,
  output logic [RR_WIDTH-1:0]          o_rr_interval,
  output logic                         o_rr_valid
);

  qrs_win_state_t state, state_nxt;
  logic above, below;
  logic win_tc, ref_tc;
  logic beat_nxt, missed_nxt;

  assign above = i_ce & i_feature_valid & (i_feature > i_threshold);
  assign below = i_ce & i_feature_valid & (i_feature <= i_threshold);

  // Counters are held cleared outside their own state, so entry always starts at zero.
  sample_counter #(.MAX(WIN_LEN)) u_win_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (state != WINDOW),
    .ce  (i_ce),
    .tc  (win_tc)
  );

  sample_counter #(.MAX(REFRACT_LEN)) u_ref_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (state != REFRACT),
    .ce  (i_ce),
    .tc  (ref_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = 1'b0;
    missed_nxt = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (below) state_nxt = ARMED;
      end
      ARMED: begin
        if (above) state_nxt = WINDOW;
      end
      WINDOW: begin
        // A hit beats a coincident timeout.
        if (i_extremum_found) begin
          state_nxt = REFRACT;
          beat_nxt  = 1'b1;
        end else if (i_ce && win_tc) begin
          state_nxt  = WAIT_LOW;
          missed_nxt = 1'b1;
        end
      end
      REFRACT: begin
        if (i_ce && ref_tc) state_nxt = WAIT_LOW;
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_qrs_win_active    <= 1'b0;
      o_refractory_active <= 1'b0;
      o_beat              <= 1'b0;
      o_missed            <= 1'b0;
    end else begin
      o_qrs_win_active    <= (state_nxt == WINDOW);
      o_refractory_active <= (state_nxt == REFRACT);
      o_beat              <= beat_nxt;
      o_missed            <= missed_nxt;
    end
  end

`ifdef QRS_WIN_CTRL_RR_EN
  localparam logic [RR_WIDTH-1:0] RR_MAX = '1;

  logic [RR_WIDTH-1:0] rr_cnt;
  logic                first_beat;

  // The first beat after reset has no predecessor, so it only restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_cnt        <= '0;
      first_beat    <= 1'b1;
      o_rr_interval <= '0;
      o_rr_valid    <= 1'b0;
    end else begin
      o_rr_valid <= 1'b0;
      if (beat_nxt) begin
        o_rr_interval <= rr_cnt;
        rr_cnt        <= {{(RR_WIDTH-1){1'b0}}, i_ce};
        o_rr_valid    <= ~first_beat;
        first_beat    <= 1'b0;
      end else if (i_ce && (rr_cnt != RR_MAX)) begin
        rr_cnt <= rr_cnt + 1'b1;
      end
    end
  end
`else
  assign o_rr_interval = '0;
  assign o_rr_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_qrs_win_ctrl.sv
// tb/tb_qrs_win_ctrl.sv - randomized bench for qrs_win_ctrl against a behavioural model
module tb_qrs_win_ctrl;

  localparam int DW = 11;
  localparam int WL = 36;
  localparam int RL = 72;
  localparam int RW = 11;
  localparam int RR_SAT = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic fv = 1'b0;
  logic hit = 1'b0;
  logic signed [DW-1:0] feat = '0;
  logic signed [DW-1:0] thr = '0;
  logic win_active, ref_active, beat, missed, rr_valid;
  logic [RW-1:0] rr_interval;

  qrs_win_ctrl #(
    .DATA_WIDTH(DW), .WIN_LEN(WL), .REFRACT_LEN(RL), .RR_WIDTH(RW)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ce                (ce),
    .i_feature           (feat),
    .i_feature_valid     (fv),
    .i_threshold         (thr),
    .i_extremum_found    (hit),
    .o_qrs_win_active    (win_active),
    .o_refractory_active (ref_active),
    .o_beat              (beat),
    .o_missed            (missed),
    .o_rr_interval       (rr_interval),
    .o_rr_valid          (rr_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase flags plus samples-remaining budgets.
  bit m_waiting, m_armed, m_in_win, m_in_ref;
  int m_win_left, m_ref_left;
  int m_samples_since_beat;
  bit m_seen_beat;
  bit e_beat, e_missed, e_rrv;
  int e_rr;
  int thr_i;

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 1; m_armed = 0; m_in_win = 0; m_in_ref = 0;
    m_win_left = 0; m_ref_left = 0;
    m_samples_since_beat = 0; m_seen_beat = 0;
    e_beat = 0; e_missed = 0; e_rrv = 0; e_rr = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input int f, input bit h);
    bit ab, bl, took_beat;
    ab = c && v && (f > thr_i);
    bl = c && v && (f <= thr_i);
    e_beat = 0; e_missed = 0; e_rrv = 0; took_beat = 0;
    if (m_in_win) begin
      if (h) begin
        took_beat = 1; m_in_win = 0; m_in_ref = 1; m_ref_left = RL;
      end else if (c) begin
        m_win_left--;
        if (m_win_left == 0) begin
          e_missed = 1; m_in_win = 0; m_waiting = 1;
        end
      end
    end else if (m_in_ref) begin
      if (c) begin
        m_ref_left--;
        if (m_ref_left == 0) begin
          m_in_ref = 0; m_waiting = 1;
        end
      end
    end else if (m_waiting) begin
      if (bl) begin
        m_waiting = 0; m_armed = 1;
      end
    end else if (m_armed) begin
      if (ab) begin
        m_armed = 0; m_in_win = 1; m_win_left = WL;
      end
    end
`ifdef QRS_WIN_CTRL_RR_EN
    if (took_beat) begin
      e_rr = (m_samples_since_beat > RR_SAT) ? RR_SAT : m_samples_since_beat;
      e_rrv = m_seen_beat;
      m_seen_beat = 1;
      m_samples_since_beat = c ? 1 : 0;
    end else if (c) begin
      m_samples_since_beat++;
    end
`endif
    e_beat = took_beat;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".win"}, 32'(win_active), int'(m_in_win));
    check_val({tag, ".ref"}, 32'(ref_active), int'(m_in_ref));
    check_val({tag, ".beat"}, 32'(beat), int'(e_beat));
    check_val({tag, ".missed"}, 32'(missed), int'(e_missed));
    check_val({tag, ".rr"}, 32'(rr_interval), e_rr);
    check_val({tag, ".rrv"}, 32'(rr_valid), int'(e_rrv));
  endtask

  // Called at a falling edge; drives one sample and checks the registered response.
  task automatic step(input string tag, input bit c, input bit v, input int f, input bit h);
    ce = c; fv = v; feat = f[DW-1:0]; hit = h;
    model_step(c, v, f, h);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic set_thr(input int t);
    thr_i = t;
    thr = t[DW-1:0];
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_val("arst.win", 32'(win_active), 0);
    check_val("arst.ref", 32'(ref_active), 0);
    check_val("arst.beat", 32'(beat), 0);
    check_val("arst.missed", 32'(missed), 0);
    check_val("arst.rr", 32'(rr_interval), 0);
    check_val("arst.rrv", 32'(rr_valid), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all("post_rst");
  endtask

  task automatic run_random(input string tag, input int n, input int ce_mode, input int hit_pct);
    bit hi;
    int f, c;
    hi = 0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 15) == 0) hi = ~hi;
      if ($urandom_range(0, 9) == 0) f = thr_i;
      else if (hi) f = thr_i + 1 + int'($urandom_range(0, 200));
      else f = thr_i - int'($urandom_range(0, 200));
      case (ce_mode)
        0: c = 1;
        1: c = (k % 4 == 0) ? 1 : 0;
        default: c = int'($urandom_range(0, 1));
      endcase
      step(tag, c[0], ($urandom_range(0, 7) != 0), f, (int'($urandom_range(0, 99)) < hit_pct));
    end
  endtask

  int cnt_a, cnt_b;

  initial begin
    model_reset();
    set_thr(100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all("reset");

    // Arm, open, hit on window cycle 10, measure refractory length.
    step("arm", 1, 1, 50, 0);
    step("open", 1, 1, 150, 0);
    check_val("win_rise", 32'(win_active), 1);
    for (int k = 0; k < 9; k++) step("win", 1, 1, 150, 0);
    step("hit10", 1, 1, 150, 1);
    check_val("hit10_beat", 32'(beat), 1);
    cnt_a = int'(ref_active);
    for (int k = 0; k < 90; k++) begin
      step("refr", 1, 1, 150, 0);
      cnt_a += int'(ref_active);
    end
    check_val("refract_len", 32'(cnt_a), RL);

    // Window with no hit, sustained high feature must not reopen.
    step("arm2", 1, 1, 50, 0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 120; k++) begin
      step("nohit", 1, 1, 150, 0);
      cnt_a += int'(win_active);
      cnt_b += int'(missed);
    end
    check_val("win_len", 32'(cnt_a), WL);
    check_val("missed_cnt", 32'(cnt_b), 1);

    // Hit on the last window sample.
    step("arm3", 1, 1, 100, 0);
    step("open3", 1, 1, 101, 0);
    for (int k = 0; k < WL - 1; k++) step("win3", 1, 1, 101, 0);
    step("lasthit", 1, 1, 101, 1);
    check_val("last_beat", 32'(beat), 1);
    check_val("last_missed", 32'(missed), 0);
    check_val("last_ref", 32'(ref_active), 1);
    step("hit_in_ref", 1, 1, 50, 1);
    check_val("ref_hit_nobeat", 32'(beat), 0);
    for (int k = 0; k < RL; k++) step("ref3", 1, 1, 50, 0);
    step("hit_armed", 1, 1, 50, 1);
    check_val("armed_hit_nobeat", 32'(beat), 0);

    // Open a window, then reset asynchronously in the middle of it.
    step("open4", 1, 1, 150, 0);
    for (int k = 0; k < 5; k++) step("win4", 1, 1, 150, 0);
    async_reset();

    // Two beats 200 samples apart.
    step("arm5", 1, 1, 50, 0);
    step("open5", 1, 1, 150, 0);
    step("beat_a", 1, 1, 150, 1);
    check_val("first_rrv", 32'(rr_valid), 0);
    for (int k = 1; k < 200; k++) step("gap", 1, 1, (k < 180) ? 50 : 150, 0);
    step("beat_b", 1, 1, 150, 1);
    check_val("second_beat", 32'(beat), 1);
`ifdef QRS_WIN_CTRL_RR_EN
    check_val("rr_200", 32'(rr_interval), 200);
    check_val("rrv_200", 32'(rr_valid), 1);
`else
    check_val("rr_off", 32'(rr_interval), 0);
    check_val("rrv_off", 32'(rr_valid), 0);
`endif

    // Sparse sample enable, then long silence to saturate the RR count.
    for (int k = 0; k < RL * 4; k++) step("drain", (k % 4 == 0), 1, 50, 0);
    run_random("ce4", 2000, 1, 2);
    run_random("quiet", 2200, 0, 0);

    for (int s = 0; s < 8; s++) begin
      set_thr(int'($urandom_range(0, 1000)) - 500);
      run_random("rnd", 1500, s % 3, 1 + (s % 4) * 3);
      if (s == 4) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
